conv_window_scheduler: RTL and testbench
========================================

// Module: conv_window_scheduler
// PURPOSE
//   Sequences the 3x3 line buffer and conv kernel over a runtime-sized WxH ifmap stream.
//   Accepts pixels via valid/ready; advances line buffer and kernel only on accepted or drain beats.
//   Tags valid 3x3 windows through the kernel latency and emits (W-2)*(H-2) ofmap words with backpressure.
//   Sits between the ifmap source (DMA/ICB side) and the ofmap sink, replacing fixed-count sequencing.
// PARAMETERS
//   DW    16  pixel / result data width
//   CW    16  width of cfg_w, cfg_h, row/col counters
//   KLAT  2   kernel latency in advance beats (>=1): window of beat n appears on k_result at beat n+KLAT
// PORTS
//   clk         in   1     clock
//   rst         in   1     synchronous reset, active-high
//   start       in   1     launch a frame; sampled only in IDLE
//   cfg_w       in   CW    ifmap width, sampled with start
//   cfg_h       in   CW    ifmap height, sampled with start
//   busy        out  1     high in RUN or DRAIN
//   done        out  1     1-cycle pulse: frame complete
//   err_cfg     out  1     1-cycle pulse: start rejected (cfg_w<3 or cfg_h<3)
//   in_valid    in   1     ifmap pixel valid
//   in_ready    out  1     scheduler accepts pixel
//   in_data     in   DW    ifmap pixel, raster order
//   lb_shift_en out  1     line-buffer shift enable (= adv)
//   lb_data     out  DW    pixel to line buffer (in_data on RUN beats, 0 on DRAIN beats)
//   k_en        out  1     kernel pipeline enable (= adv)
//   k_result    in   DW    kernel output
//   out_valid   out  1     ofmap word valid
//   out_ready   in   1     sink accepts ofmap word
//   out_data    out  DW    ofmap word (registered)
//   out_last    out  1     high with final ofmap word of frame
// BEHAVIOUR
//   Reset: state=IDLE; busy, done, err_cfg, in_ready, lb_shift_en, k_en, out_valid, out_last=0;
//     out_data, lb_data=0; row, col, tag pipe, out count cleared. Reset mid-frame aborts, no done.
//   States: IDLE, RUN, DRAIN.
//     IDLE: start & cfg ok -> latch W,H, clear counters, RUN (next cycle). start & bad cfg -> err_cfg pulse, stay IDLE.
//     RUN: last pixel (row=H-1, col=W-1) accepted -> DRAIN.
//     DRAIN: tag pipe empty & out_valid=0 -> IDLE with done=1 that cycle (registered pulse next edge).
//   start outside IDLE ignored. cfg_* changes after start have no effect.
//   slot_free = !out_valid | out_ready. in_ready = (state==RUN) & slot_free (combinational).
//   adv = (RUN & in_valid & in_ready) | (DRAIN & slot_free & tag pipe non-empty).
//   Counters on RUN accept: col++ ; col==W-1 -> col=0, row++. No counting on DRAIN beats.
//   Window tag: accepted pixel with row>=2 & col>=2 -> tag=1, plus last flag if row=H-1 & col=W-1.
//   Tag pipe: KLAT-deep shift register, shifts only on adv (holds on stall), inserts 0 on DRAIN beats.
//   Output reg: on adv with tag[KLAT-1]=1 -> out_data<=k_result, out_valid<=1, out_last<=last flag.
//     Else if out_valid & out_ready -> out_valid<=0, out_last<=0. Load and pop same cycle allowed.
//   out_data/out_last stable while out_valid & !out_ready.
//   Exactly (W-2)*(H-2) words per frame; out_last on the last only. Total outputs counted (CW*2 bits) for done check.
//   lb_data = in_data when RUN, else 0. No combinational path from out_ready to out_data.
// TESTING
//   T1 W=4,H=4, pixels 1..16, kernel model all-ones weights, out_ready=1 -> 4 words 54,63,90,99; last on 99; done 1 pulse.
//   T2 W=5,H=3 raster 0..14, in_valid gaps every 3rd cycle -> 3 words, lb_shift_en only on accepted beats, done after last.
//   T3 T1 with out_ready toggling 1010... -> same 4 words in order, out_data stable while stalled, in_ready=0 whenever out_valid & !out_ready.
//   T4 start with cfg_w=2,cfg_h=8 -> err_cfg 1 pulse, busy=0, in_ready=0; then valid start with W=3,H=3 -> 1 word, out_last=1.
//   T5 rst=1 mid-RUN after 6 pixels of W=4,H=4 -> next cycle IDLE, all outputs 0, no done; restart gives T1 results.
//   T6 start pulsed during RUN with cfg_w=9 -> ignored; frame completes with original W=4,H=4 counts.

Source files
------------

// File: rtl/conv_window_scheduler_if.sv
// conv_window_scheduler_if: ifmap pixel stream in, ofmap word stream out
interface conv_window_scheduler_if #(
    parameter int DW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    modport master (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
    modport slave (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/conv_window_scheduler.sv
// conv_window_scheduler: sequences line buffer and 3x3 kernel over a runtime WxH frame
module conv_window_scheduler #(
    parameter int DW   = 16,
    parameter int CW   = 16,
    parameter int KLAT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic [CW-1:0]            cfg_w_i,
    input  logic [CW-1:0]            cfg_h_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_cfg_o,
    output logic                     lb_shift_en_o,
    output logic [DW-1:0]            lb_data_o,
    output logic                     k_en_o,
    input  logic [DW-1:0]            k_result_i,
    conv_window_scheduler_if.master  s
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t          state_q, state_d;
    logic [CW-1:0]   w_q, h_q, row_q, col_q;
    logic [KLAT-1:0] tag_v_q, tag_v_d, tag_l_q, tag_l_d;
    logic [DW-1:0]   out_data_q;
    logic            out_valid_q, out_last_q, done_q, err_q;
    logic [2*CW-1:0] out_cnt_q, total_q;
    logic            cfg_ok, launch, slot_free, pipe_empty, in_fire, adv, last_px;
    logic            new_v, load, finish;
    assign cfg_ok     = (cfg_w_i >= CW'(3)) && (cfg_h_i >= CW'(3));
    assign launch     = (state_q == IDLE) && start_i && cfg_ok;
    assign slot_free  = !out_valid_q || s.out_ready;
    assign pipe_empty = (tag_v_q == '0);
    assign in_fire    = (state_q == RUN) && s.in_valid && slot_free;
    assign adv        = in_fire || ((state_q == DRAIN) && slot_free && !pipe_empty);
    assign last_px    = (row_q == h_q - 1'b1) && (col_q == w_q - 1'b1);
    assign new_v      = in_fire && (row_q >= CW'(2)) && (col_q >= CW'(2));
    assign load       = adv && tag_v_q[KLAT-1];
    assign finish     = (state_q == DRAIN) && pipe_empty && !out_valid_q && (out_cnt_q == total_q);
    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;
    assign err_cfg_o     = err_q;
    assign lb_shift_en_o = adv;
    assign k_en_o        = adv;
    assign lb_data_o     = (state_q == RUN) ? s.in_data : '0;
    assign s.in_ready    = (state_q == RUN) && slot_free;
    assign s.out_valid   = out_valid_q;
    assign s.out_data    = out_data_q;
    assign s.out_last    = out_last_q;
    // next state: launch on good start, drain after last pixel, idle once everything is out
    always_comb begin
        state_d = launch ? RUN :
                  ((state_q == RUN) && in_fire && last_px) ? DRAIN :
                  finish ? IDLE : state_q;
    end
    // window tag pipe advances with the kernel; drain beats push empty tags
    always_comb begin
        tag_v_d = tag_v_q;
        tag_l_d = tag_l_q;
        if (adv) begin
            tag_v_d[0] = new_v;
            tag_l_d[0] = new_v && last_px;
            for (int i = 1; i < KLAT; i++) begin
                tag_v_d[i] = tag_v_q[i-1];
                tag_l_d[i] = tag_l_q[i-1];
            end
        end
    end
    // state, pulse outputs and tag pipe registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            tag_v_q <= '0;
            tag_l_q <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= finish;
            err_q   <= (state_q == IDLE) && start_i && !cfg_ok;
            tag_v_q <= launch ? '0 : tag_v_d;
            tag_l_q <= launch ? '0 : tag_l_d;
        end
    end
    // frame geometry latch and raster position counters
    always_ff @(posedge clk) begin
        if (rst) begin
            w_q     <= '0;
            h_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            total_q <= '0;
        end else if (launch) begin
            w_q     <= cfg_w_i;
            h_q     <= cfg_h_i;
            row_q   <= '0;
            col_q   <= '0;
            total_q <= (2*CW)'(cfg_w_i - CW'(2)) * (2*CW)'(cfg_h_i - CW'(2));
        end else if (in_fire) begin
            col_q <= (col_q == w_q - 1'b1) ? '0 : col_q + 1'b1;
            row_q <= (col_q == w_q - 1'b1) ? row_q + 1'b1 : row_q;
        end
    end
    // output register: capture tagged kernel results, hold under backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_cnt_q   <= '0;
        end else begin
            if (load) begin
                out_data_q  <= k_result_i;
                out_valid_q <= 1'b1;
                out_last_q  <= tag_l_q[KLAT-1];
            end else if (out_valid_q && s.out_ready) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
            out_cnt_q <= launch ? '0 : load ? out_cnt_q + 1'b1 : out_cnt_q;
        end
    end
endmodule

// File: tb/tb_conv_window_scheduler.sv
// tb_conv_window_scheduler: directed frames through the scheduler with a line buffer + 3x3 sum kernel model
module tb_conv_window_scheduler;
    logic        clk = 0, rst = 1, start = 0, toggle = 0;
    logic [15:0] cfg_w = 0, cfg_h = 0, k_result, lb_data;
    logic        busy, done, err_cfg, lb_shift_en, k_en;
    int          checks = 0, failures = 0, done_cnt = 0, err_cnt = 0, shift_cnt = 0, tb_w = 4;
    logic [16:0] got[$];
    logic [16:0] held;
    logic        hold_pending = 0;
    logic [15:0] sr[0:40];
    logic [15:0] s1 = 0, s2 = 0, win_sum;
    conv_window_scheduler_if #(.DW(16)) s ();
    conv_window_scheduler #(.DW(16), .CW(16), .KLAT(2)) dut (
        .clk(clk), .rst(rst), .start_i(start), .cfg_w_i(cfg_w), .cfg_h_i(cfg_h),
        .busy_o(busy), .done_o(done), .err_cfg_o(err_cfg), .lb_shift_en_o(lb_shift_en),
        .lb_data_o(lb_data), .k_en_o(k_en), .k_result_i(k_result), .s(s.master)
    );
    always #5 clk = ~clk;
    initial for (int i = 0; i <= 40; i++) sr[i] = '0;
    always_comb win_sum = lb_data + sr[0] + sr[1] + sr[tb_w-1] + sr[tb_w] + sr[tb_w+1]
                        + sr[2*tb_w-1] + sr[2*tb_w] + sr[2*tb_w+1];
    always @(posedge clk) if (lb_shift_en) begin
        for (int i = 40; i > 0; i--) sr[i] <= sr[i-1];
        sr[0] <= lb_data;
        s1 <= win_sum;
        s2 <= s1;
    end
    assign k_result = s2;
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    always @(negedge clk) begin
        if (s.out_valid && s.out_ready) got.push_back({s.out_last, s.out_data});
        if (done) done_cnt++;
        if (err_cfg) err_cnt++;
        if (lb_shift_en) shift_cnt++;
        if (!rst) begin
            if (hold_pending && s.out_valid) chk("stable_while_stalled", {15'd0, s.out_last, s.out_data}, {15'd0, held});
            if (s.out_valid && !s.out_ready) chk("in_ready_stall", {31'd0, s.in_ready}, 0);
            if (s.in_ready) chk("shift_on_accept", {31'd0, lb_shift_en}, {31'd0, s.in_valid});
            chk("k_en_eq_shift", {31'd0, k_en}, {31'd0, lb_shift_en});
        end
        hold_pending = s.out_valid && !s.out_ready;
        held = {s.out_last, s.out_data};
    end
    initial begin
        s.out_ready = 1;
        forever begin
            @(posedge clk); #1;
            s.out_ready = toggle ? ~s.out_ready : 1'b1;
        end
    end
    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    task automatic step();
        @(posedge clk); #1;
    endtask
    task automatic start_frame(int w, int h);
        cfg_w = 16'(w); cfg_h = 16'(h); start = 1;
        step();
        start = 0;
    endtask
    task automatic send_px(int lo, int hi, bit gap);
        logic acc;
        int   n;
        for (int p = lo; p <= hi; p++) begin
            if (gap && (p % 2 == 1)) begin
                s.in_valid = 0;
                step();
            end
            s.in_valid = 1; s.in_data = 16'(p); n = 0;
            do begin
                @(negedge clk); acc = s.in_ready;
                @(posedge clk); #1; n++;
            end while (!acc && n < 200);
            chk("px_accept", {31'd0, acc}, 1);
        end
        s.in_valid = 0;
    endtask
    task automatic wait_done(int prev);
        int n = 0;
        while (done_cnt == prev && n < 400) begin step(); n++; end
        chk("done_seen", done_cnt, prev + 1);
        repeat (4) step();
        chk("done_one_pulse", done_cnt, prev + 1);
        chk("busy_after_done", {31'd0, busy}, 0);
    endtask
    task automatic chk_words(string tag, int n, int e0, int e1, int e2, int e3);
        int e[4] = '{e0, e1, e2, e3};
        chk({tag, "_count"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++) begin
            chk({tag, "_data"}, {16'd0, got[i][15:0]}, e[i]);
            chk({tag, "_last"}, {31'd0, got[i][16]}, (i == n - 1) ? 1 : 0);
        end
    endtask
    initial begin
        s.in_valid = 0; s.in_data = 0;
        repeat (3) step();
        @(negedge clk);
        chk("reset_ctl", {24'd0, busy, done, err_cfg, s.in_ready, lb_shift_en, k_en, s.out_valid, s.out_last}, 0);
        chk("reset_data", {s.out_data, lb_data}, 0);
        rst = 0;
        step();
        // T1: 4x4, pixels 1..16
        got.delete(); tb_w = 4;
        start_frame(4, 4);
        chk("t1_busy", {31'd0, busy}, 1);
        send_px(1, 16, 0);
        wait_done(0);
        chk_words("t1", 4, 54, 63, 90, 99);
        // T2: 5x3, raster 0..14 with input gaps
        got.delete(); tb_w = 5; shift_cnt = 0;
        start_frame(5, 3);
        send_px(0, 14, 1);
        wait_done(1);
        chk_words("t2", 3, 54, 63, 72, 0);
        chk("t2_shift_beats", shift_cnt, 17);
        // T3: T1 with out_ready toggling
        got.delete(); tb_w = 4; toggle = 1;
        start_frame(4, 4);
        send_px(1, 16, 0);
        wait_done(2);
        toggle = 0;
        step();
        chk_words("t3", 4, 54, 63, 90, 99);
        // T4: bad config rejected, then 3x3
        start_frame(2, 8);
        @(negedge clk);
        chk("t4_err", {29'd0, err_cfg, busy, s.in_ready}, 32'b100);
        step();
        @(negedge clk);
        chk("t4_err_pulse", err_cnt, 1);
        chk("t4_idle", {30'd0, busy, err_cfg}, 0);
        got.delete(); tb_w = 3;
        step();
        start_frame(3, 3);
        send_px(1, 9, 0);
        wait_done(3);
        chk_words("t4", 1, 45, 0, 0, 0);
        // T5: reset mid-frame, then restart
        got.delete(); tb_w = 4;
        start_frame(4, 4);
        send_px(1, 6, 0);
        rst = 1;
        step();
        @(negedge clk);
        chk("t5_ctl", {24'd0, busy, done, err_cfg, s.in_ready, lb_shift_en, k_en, s.out_valid, s.out_last}, 0);
        chk("t5_data", {s.out_data, lb_data}, 0);
        rst = 0;
        step(); step();
        chk("t5_no_done", done_cnt, 4);
        chk("t5_no_words", got.size(), 0);
        start_frame(4, 4);
        send_px(1, 16, 0);
        wait_done(4);
        chk_words("t5", 4, 54, 63, 90, 99);
        // T6: start during RUN is ignored
        got.delete();
        start_frame(4, 4);
        send_px(1, 5, 0);
        cfg_w = 9; cfg_h = 9; start = 1;
        step();
        start = 0;
        send_px(6, 16, 0);
        wait_done(5);
        chk_words("t6", 4, 54, 63, 90, 99);
        chk("t6_no_err", err_cnt, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
